// File: rtl/gray_pkg.sv
// Shared constants and Gray-code helpers for the gray_counter slice.
// Both helpers operate on GRAY_MAX_WIDTH-bit words; callers zero-extend narrower values.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_step_next.sv
// Combinational next-count for one enabled step, plus limit detection.
// Build option GRAY_CNT_SAT_EN: saturate at the limits instead of wrapping.
module gray_step_next #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_cur,
  input  logic             up_dn,
  output logic [WIDTH-1:0] bin_nxt,
  output logic             limit_hit
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic at_max;
  logic at_min;

  assign at_max = &bin_cur;
  assign at_min = ~|bin_cur;

  // limit_hit marks a wrap (modulo build) or a blocked step (saturating build).
  always_comb begin
    bin_nxt   = bin_cur;
    limit_hit = 1'b0;
    if (up_dn) begin
      limit_hit = at_max;
`ifdef GRAY_CNT_SAT_EN
      if (!at_max) bin_nxt = bin_cur + ONE;
`else
      bin_nxt = bin_cur + ONE;
`endif
    end else begin
      limit_hit = at_min;
`ifdef GRAY_CNT_SAT_EN
      if (!at_min) bin_nxt = bin_cur - ONE;
`else
      bin_nxt = bin_cur - ONE;
`endif
    end
  end

endmodule

// File: rtl/gray_counter.sv
// WIDTH-bit up/down counter with a registered, skew-free Gray copy and terminal-count pulse.
// Build option GRAY_CNT_SAT_EN selects saturating rather than wrapping counts.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned     WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RESET_GRAY =
    WIDTH'(bin2gray(GRAY_MAX_WIDTH'(RESET_VAL)));

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q,   tc_d;

  logic [WIDTH-1:0] step_bin;
  logic             step_limit;

  gray_step_next #(.WIDTH(WIDTH)) u_step (
    .bin_cur   (bin_q),
    .up_dn     (up_dn),
    .bin_nxt   (step_bin),
    .limit_hit (step_limit)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (clr) begin
      bin_d = '0;
    end else if (load) begin
      bin_d = load_val;
    end else if (en) begin
      bin_d = step_bin;
      tc_d  = step_limit;
    end
    // Gray is derived from the next binary value so both registers update together.
    gray_d = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_d)));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= RESET_VAL;
      gray_q <= RESET_GRAY;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign tc       = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter at WIDTH=4, RESET_VAL=0.
// Define GRAY_CNT_SAT_EN for both bench and RTL to exercise the saturating build.
module tb_gray_counter;
  import gray_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic         clr;
  logic [W-1:0] bin_out;
  logic [W-1:0] gray_out;
  logic         tc;

  int n_vec = 0;
  int n_err = 0;

  gray_counter #(.WIDTH(W), .RESET_VAL(4'd0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .clr      (clr),
    .bin_out  (bin_out),
    .gray_out (gray_out),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] eb,
                            input logic [W-1:0] eg, input logic et);
    check({tag, ".bin"},  32'(bin_out),  32'(eb));
    check({tag, ".gray"}, 32'(gray_out), 32'(eg));
    check({tag, ".tc"},   32'(tc),       32'(et));
  endtask

  // Gray codes after each of 16 up steps from 0000 (modulo build).
  logic [W-1:0] up_gray [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                 4'b1011, 4'b1001, 4'b1000, 4'b0000};
  logic [W-1:0] ld_bin  [5]  = '{4'b1011, 4'b0111, 4'b0101, 4'b1100, 4'b1111};
  logic [W-1:0] ld_gray [5]  = '{4'b1110, 4'b0100, 4'b0111, 4'b1010, 4'b1000};

  initial begin
    logic [W-1:0] prev_gray;
    logic [W-1:0] eb;

    rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = '0; clr = 1'b0;
    step(); step();
    check_outs("reset", 4'b0000, 4'b0000, 1'b0);

    rst_n = 1'b1;
    prev_gray = gray_out;
    for (int i = 0; i < 16; i++) begin
      step();
`ifdef GRAY_CNT_SAT_EN
      eb = (i == 15) ? 4'd15 : W'(i + 1);
      check_outs($sformatf("up%0d", i), eb, (i == 15) ? 4'b1000 : up_gray[i], i == 15);
`else
      eb = W'(i + 1);
      check_outs($sformatf("up%0d", i), eb, up_gray[i], i == 15);
      check($sformatf("up%0d.onebit", i), 32'($countones(gray_out ^ prev_gray)), 32'd1);
`endif
      check($sformatf("up%0d.g2b", i), gray2bin(32'(gray_out)), 32'(eb));
      prev_gray = gray_out;
    end

    // Move to 0110 from a known point, then reset asynchronously between edges.
    en = 1'b0; clr = 1'b1; step(); clr = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check_outs("pre_rst", 4'b0110, 4'b0101, 1'b0);
    load = 1'b1; load_val = 4'b1001;
    rst_n = 1'b0;
    #2;
    check_outs("async_rst", 4'b0000, 4'b0000, 1'b0);
    step();
    check_outs("rst_hold", 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    step();
    check_outs("post_rst_load", 4'b1001, 4'b1101, 1'b0);

    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_val = ld_bin[i];
      step();
      check_outs($sformatf("load%0d", i), ld_bin[i], ld_gray[i], 1'b0);
    end
    load = 1'b0;
    step();
    check_outs("hold", 4'b1111, 4'b1000, 1'b0);

    // Down wrap from zero.
    clr = 1'b1; step(); clr = 1'b0;
    check_outs("clr", 4'b0000, 4'b0000, 1'b0);
    en = 1'b1; up_dn = 1'b0;
    step();
`ifdef GRAY_CNT_SAT_EN
    check_outs("down_sat", 4'b0000, 4'b0000, 1'b1);
    load = 1'b1; load_val = 4'b1111; step(); load = 1'b0;
`else
    check_outs("down_wrap", 4'b1111, 4'b1000, 1'b1);
`endif
    step();
    check_outs("down_next", 4'b1110, 4'b1001, 1'b0);
    up_dn = 1'b1;
    step();
    check_outs("dir_change", 4'b1111, 4'b1000, 1'b0);
    en = 1'b0;
    step();
    check_outs("en_low", 4'b1111, 4'b1000, 1'b0);

    // Priority: clr beats load beats en.
    clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'b1010;
    step();
    check_outs("prio_clr", 4'b0000, 4'b0000, 1'b0);
    clr = 1'b0;
    step();
    check_outs("prio_load", 4'b1010, 4'b1111, 1'b0);

    // Behaviour at the top limit.
    load_val = 4'b1111; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
`ifdef GRAY_CNT_SAT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs($sformatf("sat_up%0d", i), 4'b1111, 4'b1000, 1'b1);
    end
`else
    step();
    check_outs("up_wrap", 4'b0000, 4'b0000, 1'b1);
    step();
    check_outs("up_after_wrap", 4'b0001, 4'b0001, 1'b0);
`endif
    en = 1'b0;
    step();
    check("tc_drop", 32'(tc), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised WIDTH-bit up/down counter that keeps a binary state and a registered Gray-coded copy of it.
- Successor to the combinational 4-bit binary-to-Gray converter. Adds width generalisation, count direction, load, clear and a terminal-count flag.
- Intended as the pointer generator for async FIFOs and other clock-domain crossings. Only gray_out may be sampled by another clock domain.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..32
RESET_VAL, 0, binary value loaded on reset; must fit in WIDTH bits

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  count enable; one step per cycle while high
up_dn  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load of load_val
load_val  input  WIDTH  binary value to load
clr  input  1  synchronous clear to zero
bin_out  output  WIDTH  registered binary count
gray_out  output  WIDTH  registered Gray code of bin_out, equal to bin_out ^ (bin_out >> 1)
tc  output  1  registered terminal-count pulse

Behaviour:
- Reset, asynchronous on rst_n low, immediate and independent of clk:
  - bin_out = RESET_VAL
  - gray_out = bin2gray(RESET_VAL)
  - tc = 0
- Synchronous priority per rising edge: clr > load > en > hold.
- clr: bin_out = 0, gray_out = 0, tc = 0.
- load: bin_out = load_val, gray_out = bin2gray(load_val), tc = 0.
- en with up_dn = 1: bin_out = bin_out + 1, modulo 2^WIDTH.
- en with up_dn = 0: bin_out = bin_out - 1, modulo 2^WIDTH.
- Gray generation:
  - gray_out is computed from the next binary value and registered on the same edge as bin_out.
  - The two outputs are therefore always mutually consistent, with no skew cycle.
  - No combinational path from any input to gray_out.
- Latency: 1 cycle from en/load/clr to the new output values.
- Terminal count:
  - tc = 1 for exactly the cycle in which the outputs show a wrapped value.
  - Up wrap: bin_out goes from 2^WIDTH-1 to 0. Down wrap: bin_out goes from 0 to 2^WIDTH-1.
  - In every other cycle tc = 0, including cycles following load or clr.
- Single-bit property: every en step changes exactly one bit of gray_out, including across wrap. load and clr may change multiple bits.
- Direction change mid-count is legal. The next step simply moves in the new direction.
- en held low: all outputs hold, and tc drops to 0 after one cycle.
- Reset mid-operation: overrides any in-flight load/clr/en. The first edge after rst_n deasserts behaves per the priority rules.
- WIDTH = 2 with up wrap: gray sequence 00, 01, 11, 10, 00.

Optional Feature:
GRAY_CNT_SAT_EN
- Defined: the counter saturates instead of wrapping.
  - An up step at 2^WIDTH-1, or a down step at 0, holds the count.
  - tc = 1 in the cycle after each blocked step, for as long as stepping continues at the limit.
- Undefined: modulo wrap and tc-on-wrap behaviour as described above.
- In both builds, load and clr are unaffected.

Decomposition:
- Package gray_pkg holds:
  - constant GRAY_MAX_WIDTH = 32
  - function bin2gray(b) = b ^ (b >> 1)
  - function gray2bin(g) = prefix-XOR from the MSB
- The bench checker uses gray2bin from the package.
- One natural sub-module, gray_step_next: combinational next-binary computation plus wrap/saturate detection. The top level keeps all registers and the priority mux.

Test Plan (WIDTH=4, RESET_VAL=0):
- Reset: hold rst_n = 0 while en = 1 -> bin_out = 0000, gray_out = 0000, tc = 0. Assert rst_n mid-count at bin 0110 -> outputs return to 0 immediately, before the next edge.
- Up count: en = 1, up_dn = 1 for 16 cycles -> gray_out steps 0000, 0001, 0011, 0010, 0110, …, 1000, 0000. tc = 1 only with the final 0000. Exactly one bit changes per step.
- Load values: load_val = 1011 / 0111 / 0101 / 1100 / 1111 -> gray_out = 1110 / 0100 / 0111 / 1010 / 1000 one cycle later, tc = 0.
- Down wrap: from 0000 with en = 1, up_dn = 0 -> bin_out = 1111, gray_out = 1000, tc = 1 for one cycle. Next step gives 1110 / 1001, tc = 0.
- Priority: clr = 1, load = 1, en = 1 with load_val = 1010 -> bin_out = 0000. Then load = 1, en = 1 -> bin_out = 1010, not 1011.
- With GRAY_CNT_SAT_EN defined: at 1111 with en = 1, up_dn = 1 for 3 cycles -> bin_out stays 1111, gray_out stays 1000, tc = 1 each cycle.
